rv32im_br_pred: RTL and testbench

- Parametrised successor to the combinational branch unit.
- Resolves conditional branches, JAL and JALR, and keeps a direct-mapped branch history/target table (BHT/BTB) with saturating counters.
- Fetch gets a same-cycle prediction; EXU resolutions update the table and produce a registered redirect on mispredict.

---
 rtl/rv32im_br_pred_if.sv | 47 ++++
 rtl/rv32im_br_pred.sv | 214 +++++++++++++++++++++
 tb/tb_rv32im_br_pred.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_br_pred_if.sv
// Fetch-prediction and EXU-resolution bus of the branch predictor.
// master = fetch/EXU side, slave = predictor.
interface rv32im_br_pred_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 32,
  parameter int BR_OPCODE_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]      pred_pc_i;
  logic                       pred_hit_o;
  logic                       pred_taken_o;
  logic [ADDR_WIDTH-1:0]      pred_target_o;

  logic                       res_valid_i;
  logic [ADDR_WIDTH-1:0]      res_pc_i;
  logic                       res_conditional_i;
  logic                       res_jalr_i;
  logic [BR_OPCODE_WIDTH-1:0] res_opcode_i;
  logic [DATA_WIDTH-1:0]      rs1_i;
  logic [DATA_WIDTH-1:0]      rs2_i;
  logic [DATA_WIDTH-1:0]      imm_i;
  logic                       res_pred_taken_i;
  logic [ADDR_WIDTH-1:0]      res_pred_target_i;

  logic                       res_done_o;
  logic                       res_taken_o;
  logic                       redirect_o;
  logic [ADDR_WIDTH-1:0]      redirect_pc_o;
  logic [ADDR_WIDTH-1:0]      link_pc_o;
  logic                       misalign_o;
  logic [CNT_WIDTH-1:0]       branch_cnt_o;
  logic [CNT_WIDTH-1:0]       mispredict_cnt_o;

  modport master (
    output pred_pc_i, res_valid_i, res_pc_i, res_conditional_i, res_jalr_i, res_opcode_i,
           rs1_i, rs2_i, imm_i, res_pred_taken_i, res_pred_target_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, res_done_o, res_taken_o, redirect_o,
           redirect_pc_o, link_pc_o, misalign_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  pred_pc_i, res_valid_i, res_pc_i, res_conditional_i, res_jalr_i, res_opcode_i,
           rs1_i, rs2_i, imm_i, res_pred_taken_i, res_pred_target_i,
    output pred_hit_o, pred_taken_o, pred_target_o, res_done_o, res_taken_o, redirect_o,
           redirect_pc_o, link_pc_o, misalign_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/rv32im_br_pred.sv
// RV32IM branch resolution unit with a direct-mapped BHT/BTB: same-cycle
// fetch prediction, registered resolution/redirect one cycle after request.
module rv32im_br_pred_entry #(
  parameter int                   TAG_W      = 26,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   CTR_WIDTH  = 2,
  parameter logic [CTR_WIDTH-1:0] CTR_RST    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we,
  input  logic [TAG_W-1:0]      tag_d,
  input  logic [ADDR_WIDTH-1:0] tgt_d,
  input  logic [CTR_WIDTH-1:0]  ctr_d,
  input  logic                  uncond_d,
  output logic                  valid,
  output logic [TAG_W-1:0]      tag,
  output logic [ADDR_WIDTH-1:0] tgt,
  output logic [CTR_WIDTH-1:0]  ctr,
  output logic                  uncond
);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid  <= 1'b0;
      tag    <= '0;
      tgt    <= '0;
      ctr    <= CTR_RST;
      uncond <= 1'b0;
    end else if (we) begin
      valid  <= 1'b1;
      tag    <= tag_d;
      tgt    <= tgt_d;
      ctr    <= ctr_d;
      uncond <= uncond_d;
    end
  end
endmodule

module rv32im_br_pred #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_WIDTH   = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rv32im_br_pred_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  localparam logic [2:0] BR_OPCODE_BEQ  = 3'b000;
  localparam logic [2:0] BR_OPCODE_BNE  = 3'b001;
  localparam logic [2:0] BR_OPCODE_BLT  = 3'b100;
  localparam logic [2:0] BR_OPCODE_BGE  = 3'b101;
  localparam logic [2:0] BR_OPCODE_BLTU = 3'b110;
  localparam logic [2:0] BR_OPCODE_BGEU = 3'b111;

  // Weakly-taken is MSB only; weakly-not-taken is all ones below the MSB.
  localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WT - CTR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] FOUR   = ADDR_WIDTH'(4);

  logic [BHT_ENTRIES-1:0]                 tbl_valid;
  logic [BHT_ENTRIES-1:0]                 tbl_uncond;
  logic [BHT_ENTRIES-1:0][TAG_W-1:0]      tbl_tag;
  logic [BHT_ENTRIES-1:0][ADDR_WIDTH-1:0] tbl_tgt;
  logic [BHT_ENTRIES-1:0][CTR_WIDTH-1:0]  tbl_ctr;

  // Prediction: purely combinational from the table registers.
  logic [IDX_W-1:0] p_idx;
  logic [TAG_W-1:0] p_tag;
  logic             p_hit;

  assign p_idx = bus.pred_pc_i[IDX_W+1:2];
  assign p_tag = bus.pred_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign p_hit = tbl_valid[p_idx] && (tbl_tag[p_idx] == p_tag);

  assign bus.pred_hit_o    = p_hit;
  assign bus.pred_taken_o  = p_hit && (tbl_uncond[p_idx] || tbl_ctr[p_idx][CTR_WIDTH-1]);
  assign bus.pred_target_o = bus.pred_taken_o ? tbl_tgt[p_idx] : bus.pred_pc_i + FOUR;

  logic [ADDR_WIDTH-1:0] imm_a;
  logic [ADDR_WIDTH-1:0] rs1_a;

  if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
    assign imm_a = bus.imm_i[ADDR_WIDTH-1:0];
    assign rs1_a = bus.rs1_i[ADDR_WIDTH-1:0];
  end else begin : g_ext
    assign imm_a = {{(ADDR_WIDTH-DATA_WIDTH){bus.imm_i[DATA_WIDTH-1]}}, bus.imm_i};
    assign rs1_a = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, bus.rs1_i};
  end

  logic                  c_taken;
  logic                  c_ok;
  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] actual_next;
  logic                  mispredict;
  logic                  misalign;

  always_comb begin
    c_taken = 1'b0;
    c_ok    = 1'b1;
    case (bus.res_opcode_i)
      BR_OPCODE_BEQ:  c_taken = (bus.rs1_i == bus.rs2_i);
      BR_OPCODE_BNE:  c_taken = (bus.rs1_i != bus.rs2_i);
      BR_OPCODE_BLT:  c_taken = ($signed(bus.rs1_i) <  $signed(bus.rs2_i));
      BR_OPCODE_BGE:  c_taken = ($signed(bus.rs1_i) >= $signed(bus.rs2_i));
      BR_OPCODE_BLTU: c_taken = (bus.rs1_i <  bus.rs2_i);
      BR_OPCODE_BGEU: c_taken = (bus.rs1_i >= bus.rs2_i);
      default:        c_ok    = 1'b0;
    endcase
  end

  assign taken       = bus.res_conditional_i ? c_taken : 1'b1;
  assign target      = (!bus.res_conditional_i && bus.res_jalr_i)
                       ? ((rs1_a + imm_a) & ~ADDR_WIDTH'(1))
                       : (bus.res_pc_i + imm_a);
  assign seq_pc      = bus.res_pc_i + FOUR;
  assign actual_next = taken ? target : seq_pc;
  assign mispredict  = (bus.res_pred_taken_i != taken) ||
                       (taken && (bus.res_pred_target_i != target));
  assign misalign    = taken && (target[1:0] != 2'b00);

  // Table update: next contents of the entry addressed by the resolving PC.
  logic [IDX_W-1:0]      r_idx;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_hit;
  logic                  upd_en;
  logic [ADDR_WIDTH-1:0] upd_tgt;
  logic [CTR_WIDTH-1:0]  upd_ctr;
  logic                  upd_uncond;

  assign r_idx = bus.res_pc_i[IDX_W+1:2];
  assign r_tag = bus.res_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign r_hit = tbl_valid[r_idx] && (tbl_tag[r_idx] == r_tag);

  always_comb begin
    upd_en     = 1'b0;
    upd_tgt    = tbl_tgt[r_idx];
    upd_ctr    = tbl_ctr[r_idx];
    upd_uncond = tbl_uncond[r_idx];
    if (bus.res_conditional_i) begin
      if (c_ok && r_hit) begin
        upd_en = 1'b1;
        if (taken) begin
          upd_tgt = target;
          if (tbl_ctr[r_idx] != '1) upd_ctr = tbl_ctr[r_idx] + CTR_WIDTH'(1);
        end else if (tbl_ctr[r_idx] != '0) begin
          upd_ctr = tbl_ctr[r_idx] - CTR_WIDTH'(1);
        end
      end else if (taken) begin
        upd_en     = 1'b1;
        upd_tgt    = target;
        upd_ctr    = CTR_WT;
        upd_uncond = 1'b0;
      end
    end else begin
      upd_en     = 1'b1;
      upd_tgt    = target;
      upd_uncond = 1'b1;
    end
    upd_en = upd_en && bus.res_valid_i;
  end

  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_ent
    rv32im_br_pred_entry #(
      .TAG_W(TAG_W), .ADDR_WIDTH(ADDR_WIDTH), .CTR_WIDTH(CTR_WIDTH), .CTR_RST(CTR_WNT)
    ) u_ent (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we       (upd_en && (r_idx == IDX_W'(i))),
      .tag_d    (r_tag),
      .tgt_d    (upd_tgt),
      .ctr_d    (upd_ctr),
      .uncond_d (upd_uncond),
      .valid    (tbl_valid[i]),
      .tag      (tbl_tag[i]),
      .tgt      (tbl_tgt[i]),
      .ctr      (tbl_ctr[i]),
      .uncond   (tbl_uncond[i])
    );
  end

  // Registered resolution outputs; data fields hold between requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.res_done_o       <= 1'b0;
      bus.res_taken_o      <= 1'b0;
      bus.redirect_o       <= 1'b0;
      bus.redirect_pc_o    <= '0;
      bus.link_pc_o        <= '0;
      bus.misalign_o       <= 1'b0;
      bus.branch_cnt_o     <= '0;
      bus.mispredict_cnt_o <= '0;
    end else begin
      bus.res_done_o <= bus.res_valid_i;
      bus.redirect_o <= bus.res_valid_i && mispredict;
      if (bus.res_valid_i) begin
        bus.res_taken_o   <= taken;
        bus.redirect_pc_o <= actual_next;
        bus.link_pc_o     <= seq_pc;
        bus.misalign_o    <= misalign;
        if (bus.branch_cnt_o != '1)
          bus.branch_cnt_o <= bus.branch_cnt_o + CNT_WIDTH'(1);
        if (mispredict && (bus.mispredict_cnt_o != '1))
          bus.mispredict_cnt_o <= bus.mispredict_cnt_o + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_rv32im_br_pred.sv
// Directed bench for rv32im_br_pred: stimulus pushes expected resolutions to a
// queue, a negedge monitor pops and compares whenever res_done_o is seen.
module tb_rv32im_br_pred;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32im_br_pred_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bif ();

  rv32im_br_pred #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BHT_ENTRIES(16), .CTR_WIDTH(2), .CNT_WIDTH(CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            taken;
    logic            redir;
    logic            mis;
    logic [AW-1:0]   rpc;
    logic [AW-1:0]   link;
    logic [CW-1:0]   b;
    logic [CW-1:0]   m;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_err = 0;
  int   mb = 0;
  int   mm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bif.res_done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(bif.res_done_o), 32'd0);
      end else begin
        e_mon = q.pop_front();
        chk({e_mon.name, ".taken"},    32'(bif.res_taken_o),      32'(e_mon.taken));
        chk({e_mon.name, ".redirect"}, 32'(bif.redirect_o),       32'(e_mon.redir));
        chk({e_mon.name, ".rpc"},      bif.redirect_pc_o,         e_mon.rpc);
        chk({e_mon.name, ".link"},     bif.link_pc_o,             e_mon.link);
        chk({e_mon.name, ".misalign"}, 32'(bif.misalign_o),       32'(e_mon.mis));
        chk({e_mon.name, ".bcnt"},     32'(bif.branch_cnt_o),     32'(e_mon.b));
        chk({e_mon.name, ".mcnt"},     32'(bif.mispredict_cnt_o), 32'(e_mon.m));
      end
    end else begin
      chk("redirect_idle", 32'(bif.redirect_o), 32'd0);
    end
  end

  // Drives one resolution for the coming edge; expected fields are hand-computed.
  task automatic drive_res(input string name, input logic [31:0] pc, input logic cond,
                           input logic jalr, input logic [2:0] op, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] imm, input logic pt,
                           input logic [31:0] ptgt, input logic e_taken, input logic e_redir,
                           input logic [31:0] e_rpc, input logic e_mis);
    exp_t e;
    bif.res_pc_i          = pc;
    bif.res_conditional_i = cond;
    bif.res_jalr_i        = jalr;
    bif.res_opcode_i      = op;
    bif.rs1_i             = r1;
    bif.rs2_i             = r2;
    bif.imm_i             = imm;
    bif.res_pred_taken_i  = pt;
    bif.res_pred_target_i = ptgt;
    bif.res_valid_i       = 1'b1;
    if (!rst) begin
      if (mb < 15) mb++;
      if (e_redir && mm < 15) mm++;
      e.name  = name;
      e.taken = e_taken;
      e.redir = e_redir;
      e.mis   = e_mis;
      e.rpc   = e_rpc;
      e.link  = pc + 32'd4;
      e.b     = CW'(mb);
      e.m     = CW'(mm);
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bif.res_valid_i = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
    bif.pred_pc_i = pc;
    #1;
    chk({name, ".hit"},    32'(bif.pred_hit_o),   32'(hit));
    chk({name, ".ptaken"}, 32'(bif.pred_taken_o), 32'(tk));
    chk({name, ".ptgt"},   bif.pred_target_o,     tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bif.pred_pc_i = 32'h100;
    bif.res_valid_i = 1'b0;
    bif.res_pc_i = '0;
    bif.res_conditional_i = 1'b0;
    bif.res_jalr_i = 1'b0;
    bif.res_opcode_i = '0;
    bif.rs1_i = '0;
    bif.rs2_i = '0;
    bif.imm_i = '0;
    bif.res_pred_taken_i = 1'b0;
    bif.res_pred_target_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    lookup("rst_lk100", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("rst_done",  32'(bif.res_done_o), 32'd0);
    chk("rst_taken", 32'(bif.res_taken_o), 32'd0);
    chk("rst_rpc",   bif.redirect_pc_o, 32'd0);
    chk("rst_link",  bif.link_pc_o, 32'd0);
    chk("rst_mis",   32'(bif.misalign_o), 32'd0);
    chk("rst_bcnt",  32'(bif.branch_cnt_o), 32'd0);
    chk("rst_mcnt",  32'(bif.mispredict_cnt_o), 32'd0);

    // Train 0x100: allocate, saturate, then decay to weakly-not-taken.
    drive_res("beq1", 32'h100, 1, 0, 3'b000, 32'd5, 32'd5, 32'h40, 0, 32'h0,   1, 1, 32'h140, 0); step();
    lookup("lk100_a", 32'h100, 1'b1, 1'b1, 32'h140);
    for (int i = 0; i < 3; i++) begin
      drive_res("beq_t", 32'h100, 1, 0, 3'b000, 32'd5, 32'd5, 32'h40, 1, 32'h140, 1, 0, 32'h140, 0); step();
    end
    lookup("lk100_b", 32'h100, 1'b1, 1'b1, 32'h140);
    drive_res("bne1", 32'h100, 1, 0, 3'b001, 32'd5, 32'd5, 32'h40, 1, 32'h140, 0, 1, 32'h104, 0); step();
    lookup("lk100_c", 32'h100, 1'b1, 1'b1, 32'h140);
    drive_res("bne2", 32'h100, 1, 0, 3'b001, 32'd5, 32'd5, 32'h40, 1, 32'h140, 0, 1, 32'h104, 0); step();
    lookup("lk100_d", 32'h100, 1'b1, 1'b0, 32'h104);

    // Signed vs unsigned compares on -9 and 9.
    drive_res("blt",  32'h404, 1, 0, 3'b100, 32'hFFFFFFF7, 32'd9, 32'h10, 0, 32'h0,   1, 1, 32'h414, 0); step();
    drive_res("bltu", 32'h408, 1, 0, 3'b110, 32'hFFFFFFF7, 32'd9, 32'h10, 0, 32'h0,   0, 0, 32'h40C, 0); step();
    lookup("lk408", 32'h408, 1'b0, 1'b0, 32'h40C);
    drive_res("bgeu", 32'h40C, 1, 0, 3'b111, 32'hFFFFFFF7, 32'd9, 32'hFFFFFFF0, 1, 32'h3FC, 1, 0, 32'h3FC, 0); step();
    lookup("lk40c", 32'h40C, 1'b1, 1'b1, 32'h3FC);
    drive_res("bge",  32'h404, 1, 0, 3'b101, 32'hFFFFFFF7, 32'd9, 32'h10, 1, 32'h414, 0, 1, 32'h408, 0); step();
    lookup("lk404", 32'h404, 1'b1, 1'b0, 32'h408);
    drive_res("op010", 32'h410, 1, 0, 3'b010, 32'd5, 32'd5, 32'h10, 0, 32'h0, 0, 0, 32'h414, 0); step();
    lookup("lk410", 32'h410, 1'b0, 1'b0, 32'h414);

    // Alias at index 0: lookups during the update cycle see the old entry.
    drive_res("alias140", 32'h140, 1, 0, 3'b000, 32'd5, 32'd5, 32'h20, 0, 32'h0, 1, 1, 32'h160, 0);
    lookup("same_cyc140", 32'h140, 1'b0, 1'b0, 32'h144);
    lookup("same_cyc100", 32'h100, 1'b1, 1'b0, 32'h104);
    step();
    lookup("lk140", 32'h140, 1'b1, 1'b1, 32'h160);
    lookup("lk100_evict", 32'h100, 1'b0, 1'b0, 32'h104);

    // Jumps: JALR clears bit0, JAL to 0x206 is misaligned; counters saturate at 15.
    drive_res("jalr", 32'h300, 0, 1, 3'b000, 32'h1001, 32'd0, 32'd4, 1, 32'h1004, 1, 0, 32'h1004, 0); step();
    lookup("lk300", 32'h300, 1'b1, 1'b1, 32'h1004);
    drive_res("jal1", 32'h200, 0, 0, 3'b000, 32'd0, 32'd0, 32'd6, 0, 32'h0, 1, 1, 32'h206, 1); step();
    lookup("lk200", 32'h200, 1'b1, 1'b1, 32'h206);
    drive_res("jal2", 32'h200, 0, 0, 3'b000, 32'd0, 32'd0, 32'd6, 1, 32'h206, 1, 0, 32'h206, 1); step();
    drive_res("jal_sat", 32'h200, 0, 0, 3'b000, 32'd0, 32'd0, 32'd6, 1, 32'h206, 1, 0, 32'h206, 1); step();

    // Reset in a request cycle drops the request.
    rst = 1'b1;
    drive_res("rst_req", 32'h500, 1, 0, 3'b000, 32'd1, 32'd1, 32'h10, 0, 32'h0, 1, 1, 32'h510, 0);
    step();
    mb = 0;
    mm = 0;
    chk("rstreq_done", 32'(bif.res_done_o), 32'd0);
    chk("rstreq_bcnt", 32'(bif.branch_cnt_o), 32'd0);
    chk("rstreq_mcnt", 32'(bif.mispredict_cnt_o), 32'd0);
    lookup("rstreq_lk200", 32'h200, 1'b0, 1'b0, 32'h204);
    rst = 1'b0;
    drive_res("post_rst", 32'h200, 0, 0, 3'b000, 32'd0, 32'd0, 32'd8, 1, 32'h208, 1, 0, 32'h208, 0); step();
    lookup("lk_post", 32'h200, 1'b1, 1'b1, 32'h208);

    repeat (3) @(posedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
